// File: rtl/uart_rx_parallel.sv
// 8N1 UART receiver: 2-flop synchroniser, mid-bit sampling FSM, one byte out per good frame.
// Define UART_RX_PARITY_EN to add an even-parity bit after the data bits and a parity_error pulse.
module uart_rx_parallel #(
    parameter int CLKS_PER_BIT = 10416
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       rx_serial,
    output logic [7:0] data_parallel,
    output logic       data_valid,
    output logic       frame_error,
`ifdef UART_RX_PARITY_EN
    output logic       parity_error,
`endif
    output logic       busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [1:0]       sync_q, sync_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       data_q, data_d;
    logic             valid_q, valid_d;
    logic             ferr_q, ferr_d;
    logic             rx_s;
`ifdef UART_RX_PARITY_EN
    logic             par_q, par_d;
    logic             perr_q, perr_d;
`endif

    assign sync_d = {sync_q[0], rx_serial};
    assign rx_s   = sync_q[1];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d   = par_q;
        perr_d  = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (!rx_s) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                // Start bit is re-checked at its centre so short glitches are rejected.
                if (cnt_q == HALF_LAST) begin
                    cnt_d = '0;
                    if (!rx_s) begin
                        state_d = S_DATA;
                        idx_d   = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = rx_s;
                    if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    par_d   = rx_s;
                    state_d = S_STOP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`endif
            S_STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                    if (!rx_s) begin
                        ferr_d = 1'b1;
`ifdef UART_RX_PARITY_EN
                    end else if (par_q != ^shift_q) begin
                        perr_d = 1'b1;
`endif
                    end else begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            sync_q  <= 2'b11;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            sync_q  <= sync_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
`ifdef UART_RX_PARITY_EN
            perr_q  <= perr_d;
`endif
        end
    end

    // Assembly registers are only read after being fully written within a frame.
    always_ff @(posedge Clk) begin
        shift_q <= shift_d;
`ifdef UART_RX_PARITY_EN
        par_q   <= par_d;
`endif
    end

    assign data_parallel = data_q;
    assign data_valid    = valid_q;
    assign frame_error   = ferr_q;
`ifdef UART_RX_PARITY_EN
    assign parity_error  = perr_q;
`endif
    assign busy          = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_parallel.sv
// Bench for uart_rx_parallel: directed frames plus random frames scored against a frame-level model.
module tb_uart_rx_parallel;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic [7:0] dp;
    logic       dv;
    logic       fe;
    logic       pe;
    logic       busy;

    always #5 clk = ~clk;

    uart_rx_parallel #(.CLKS_PER_BIT(CPB)) dut (
        .Clk          (clk),
        .Rst          (rst),
        .rx_serial    (rx),
        .data_parallel(dp),
        .data_valid   (dv),
        .frame_error  (fe),
`ifdef UART_RX_PARITY_EN
        .parity_error (pe),
`endif
        .busy         (busy)
    );

`ifndef UART_RX_PARITY_EN
    assign pe = 1'b0;
    logic par_bit;
`else
    logic par_bit;
`endif

    int total = 0;
    int bad   = 0;

    // Pulse monitor: counts outputs and records every byte delivered with data_valid.
    int         dv_seen = 0;
    int         fe_seen = 0;
    int         pe_seen = 0;
    int         excl_viol = 0;
    logic [7:0] hist [0:255];

    always @(negedge clk) begin
        if (dv) begin
            hist[dv_seen[7:0]] <= dp;
            dv_seen <= dv_seen + 1;
        end
        if (fe) fe_seen <= fe_seen + 1;
        if (pe) pe_seen <= pe_seen + 1;
        if ((int'(dv) + int'(fe) + int'(pe)) > 1) excl_viol <= excl_viol + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic hold_bit(input logic b);
        rx = b;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_b);
        hold_bit(1'b0);
        for (int i = 0; i < 8; i++) hold_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        hold_bit(par_bit);
`endif
        hold_bit(stop_b);
        rx = 1'b1;
    endtask

    task automatic tx(input logic [7:0] d, input logic stop_b);
        par_bit = ^d;
        send_frame(d, stop_b);
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Frame-level model: 0 = good byte, 1 = framing error, 2 = parity error.
    function automatic int frame_outcome(input logic [7:0] d, input logic stop_b, input logic pbit);
        if (!stop_b) return 1;
`ifdef UART_RX_PARITY_EN
        if ((pbit ^ (^d)) != 1'b0) return 2;
`else
        if (pbit === 1'bz) return 2;
`endif
        return 0;
    endfunction

    logic [7:0] exp_data;
    int dv0, fe0, pe0, oc;
    logic [7:0] rd;
    logic       rs;

    initial begin
        rx = 1'b1;
        par_bit = 1'b0;
        exp_data = 8'h00;
        do_reset();
        @(negedge clk);
        check("reset_data", 32'(dp), 32'h0);
        check("reset_valid", 32'(dv), 32'h0);
        check("reset_ferr", 32'(fe), 32'h0);
        check("reset_busy", 32'(busy), 32'h0);
        idle(10);

        dv0 = dv_seen; fe0 = fe_seen;
        tx(8'h05, 1'b1);
        idle(20);
        exp_data = 8'h05;
        check("b05_count", 32'(dv_seen - dv0), 32'd1);
        check("b05_data", 32'(dp), 32'(exp_data));
        check("b05_busy", 32'(busy), 32'h0);

        dv0 = dv_seen;
        tx(8'hA5, 1'b1);
        tx(8'h07, 1'b1);
        idle(20);
        exp_data = 8'h07;
        check("b2b_count", 32'(dv_seen - dv0), 32'd2);
        check("b2b_first", 32'(hist[dv0[7:0]]), 32'hA5);
        check("b2b_second", 32'(hist[8'(dv0 + 1)]), 32'h07);
        check("b2b_data", 32'(dp), 32'(exp_data));

        dv0 = dv_seen; fe0 = fe_seen;
        rx = 1'b0;
        repeat (4) @(negedge clk);
        idle(40);
        check("glitch_valid", 32'(dv_seen - dv0), 32'd0);
        check("glitch_ferr", 32'(fe_seen - fe0), 32'd0);
        check("glitch_busy", 32'(busy), 32'h0);

        dv0 = dv_seen; fe0 = fe_seen;
        tx(8'h03, 1'b0);
        idle(20);
        check("stoplow_ferr", 32'(fe_seen - fe0), 32'd1);
        check("stoplow_valid", 32'(dv_seen - dv0), 32'd0);
        check("stoplow_data", 32'(dp), 32'(exp_data));

        hold_bit(1'b0);
        for (int i = 0; i < 4; i++) hold_bit(rd_bit(8'h06, i));
        rx = 1'b0;
        repeat (CPB / 2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_data", 32'(dp), 32'h0);
        check("midrst_busy", 32'(busy), 32'h0);
        check("midrst_valid", 32'(dv), 32'h0);
        rst = 1'b0;
        exp_data = 8'h00;
        idle(3 * CPB);
        dv0 = dv_seen;
        tx(8'h02, 1'b1);
        idle(20);
        exp_data = 8'h02;
        check("postrst_count", 32'(dv_seen - dv0), 32'd1);
        check("postrst_data", 32'(dp), 32'(exp_data));

`ifdef UART_RX_PARITY_EN
        dv0 = dv_seen; pe0 = pe_seen;
        par_bit = 1'b0;
        send_frame(8'h07, 1'b1);
        idle(20);
        check("par_bad_perr", 32'(pe_seen - pe0), 32'd1);
        check("par_bad_valid", 32'(dv_seen - dv0), 32'd0);
        check("par_bad_data", 32'(dp), 32'(exp_data));
        dv0 = dv_seen; pe0 = pe_seen;
        par_bit = 1'b1;
        send_frame(8'h07, 1'b1);
        idle(20);
        exp_data = 8'h07;
        check("par_ok_valid", 32'(dv_seen - dv0), 32'd1);
        check("par_ok_data", 32'(dp), 32'(exp_data));
`endif

        for (int n = 0; n < 14; n++) begin
            rd = 8'($urandom);
            rs = ($urandom_range(0, 3) != 0);
            par_bit = (^rd) ^ ($urandom_range(0, 3) == 0);
            dv0 = dv_seen; fe0 = fe_seen; pe0 = pe_seen;
            send_frame(rd, rs);
            idle(20);
            oc = frame_outcome(rd, rs, par_bit);
            if (oc == 0) exp_data = rd;
            check("rnd_valid", 32'(dv_seen - dv0), (oc == 0) ? 32'd1 : 32'd0);
            check("rnd_ferr", 32'(fe_seen - fe0), (oc == 1) ? 32'd1 : 32'd0);
            check("rnd_perr", 32'(pe_seen - pe0), (oc == 2) ? 32'd1 : 32'd0);
            check("rnd_data", 32'(dp), 32'(exp_data));
        end

        dv0 = dv_seen; fe0 = fe_seen;
        rx = 1'b0;
        repeat (50 * CPB) @(negedge clk);
        check("stuck_ferr_repeats", 32'((fe_seen - fe0) >= 3), 32'd1);
        check("stuck_no_valid", 32'(dv_seen - dv0), 32'd0);
        rx = 1'b1;
        do_reset();
        exp_data = 8'h00;
        idle(2 * CPB);
        check("stuck_rst_busy", 32'(busy), 32'h0);
        check("stuck_rst_data", 32'(dp), 32'(exp_data));

        check("pulse_exclusive", 32'(excl_viol), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    function automatic logic rd_bit(input logic [7:0] d, input int i);
        return d[i];
    endfunction

    initial begin
        rst = 1'b1;
        #2_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
